commit_dests: RTL and testbench



---
 rtl/commit_dests_pkg.sv | 54 +++++
 rtl/width_merge.sv | 26 ++
 rtl/commit_dests.sv | 218 +++++++++++++++++++++
 tb/tb_commit_dests.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_dests_pkg.sv
// Shared encodings for the commit_dests slice: destination kinds, register selectors,
// FSM state encoding and the holding-register record types.
package commit_dests_pkg;

    // Destination-kind bit positions; a kind with the MEM bit set is a memory write.
    localparam int OPND_DEST_REG = 0;
    localparam int OPND_DEST_MEM = 1;

    localparam logic [1:0] OPND_DEST_NONE = 2'b00;

    localparam logic [2:0] REG_EAX = 3'd0;
    localparam logic [2:0] REG_ECX = 3'd1;
    localparam logic [2:0] REG_EDX = 3'd2;
    localparam logic [2:0] REG_EBX = 3'd3;
    localparam logic [2:0] REG_ESP = 3'd4;
    localparam logic [2:0] REG_EBP = 3'd5;
    localparam logic [2:0] REG_ESI = 3'd6;
    localparam logic [2:0] REG_EDI = 3'd7;

    localparam int NUM_REGS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] sel;
        logic [31:0] val;
    } dest_t;

    typedef struct packed {
        logic        is_write;
        logic [31:0] address;
        logic [31:0] data;
    } hint_t;

    function automatic logic kind_is_none(input logic [1:0] kind);
        return kind == OPND_DEST_NONE;
    endfunction

    // Kind 11 carries the MEM bit and is therefore treated as a memory destination.
    function automatic logic kind_is_mem(input logic [1:0] kind);
        return kind[OPND_DEST_MEM];
    endfunction

    function automatic logic kind_is_reg(input logic [1:0] kind);
        return kind[OPND_DEST_REG] && !kind[OPND_DEST_MEM];
    endfunction

endpackage

// File: rtl/width_merge.sv
// Operand-width merge: overlays the written byte/word of new_val onto old_val,
// optionally into bits [15:8] for the legacy high-byte registers.
module width_merge (
    input  logic [31:0] old_val,
    input  logic [31:0] new_val,
    input  logic        reg_1byte,
    input  logic        prefix_operand_16bit,
    input  logic        high_byte,
    output logic [31:0] merged
);

    // NOTE: every path assigns merged before any branch, so no latch can be inferred.
    always_comb begin
        merged = new_val;
        if (reg_1byte) begin
            if (high_byte) begin
                merged = {old_val[31:16], new_val[7:0], old_val[7:0]};
            end else begin
                merged = {old_val[31:8], new_val[7:0]};
            end
        end else if (prefix_operand_16bit) begin
            merged = {old_val[31:16], new_val[15:0]};
        end
    end

endmodule

// File: rtl/commit_dests.sv
// Commits up to two destinations (register or memory) per request, one per cycle.
// Optional feature: define COMMIT_BYTE_REGS_EN to map 8-bit REG sel 4..7 onto AH/CH/DH/BH.
module commit_dests
    import commit_dests_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,

    input  logic [1:0]  dest0_kind,
    input  logic [31:0] dest0_sel,
    input  logic [31:0] dest0_val,
    input  logic [1:0]  dest1_kind,
    input  logic [31:0] dest1_sel,
    input  logic [31:0] dest1_val,

    input  logic        reg_1byte,
    input  logic        prefix_operand_16bit,

    input  logic        hint1_is_write,
    input  logic [31:0] hint1_address,
    input  logic [31:0] hint1_data,
    input  logic        hint2_is_write,
    input  logic [31:0] hint2_address,
    input  logic [31:0] hint2_data,

    input  logic        load_en,
    input  logic [31:0] load_eax,
    input  logic [31:0] load_ecx,
    input  logic [31:0] load_edx,
    input  logic [31:0] load_ebx,
    input  logic [31:0] load_esp,
    input  logic [31:0] load_ebp,
    input  logic [31:0] load_esi,
    input  logic [31:0] load_edi,

    output logic [31:0] eax,
    output logic [31:0] ecx,
    output logic [31:0] edx,
    output logic [31:0] ebx,
    output logic [31:0] esp,
    output logic [31:0] ebp,
    output logic [31:0] esi,
    output logic [31:0] edi,

    output logic        done,
    output logic        fault
);

    state_e      state_q, state_d;
    dest_t       d0_q, d0_d, d1_q, d1_d;
    hint_t       h1_q, h1_d, h2_q, h2_d;
    logic        r1b_q, r1b_d;
    logic        p16_q, p16_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic        fault_q, fault_d;

    logic        idle;
    logic        accept;
    logic        commit_active;
    dest_t       cur;
    logic [2:0]  reg_idx;
    logic        reg_hb;
    logic [31:0] reg_old;
    logic [31:0] reg_merged;
    logic [31:0] mem1_merged;
    logic [31:0] mem2_merged;
    logic        hint1_ok;
    logic        hint2_ok;

    // A load request in IDLE takes priority over a commit request.
    assign idle     = (state_q == IDLE);
    assign in_ready = idle && !load_en;
    assign accept   = in_ready && in_valid;

    assign commit_active = (state_q == WR0) || (state_q == WR1);

    always_comb begin
        cur     = (state_q == WR1) ? d1_q : d0_q;
        reg_idx = cur.sel[2:0];
        reg_hb  = 1'b0;
`ifdef COMMIT_BYTE_REGS_EN
        if (r1b_q && cur.sel[2]) begin
            reg_idx = {1'b0, cur.sel[1:0]};
            reg_hb  = 1'b1;
        end
`endif
        reg_old = regs_q[reg_idx];
    end

    width_merge u_reg_merge (
        .old_val              (reg_old),
        .new_val              (cur.val),
        .reg_1byte            (r1b_q),
        .prefix_operand_16bit (p16_q),
        .high_byte            (reg_hb),
        .merged               (reg_merged)
    );

    // Memory data is compared only over the written width: merge val into the hint data.
    width_merge u_mem1_merge (
        .old_val              (h1_q.data),
        .new_val              (cur.val),
        .reg_1byte            (r1b_q),
        .prefix_operand_16bit (p16_q),
        .high_byte            (1'b0),
        .merged               (mem1_merged)
    );

    width_merge u_mem2_merge (
        .old_val              (h2_q.data),
        .new_val              (cur.val),
        .reg_1byte            (r1b_q),
        .prefix_operand_16bit (p16_q),
        .high_byte            (1'b0),
        .merged               (mem2_merged)
    );

    assign hint1_ok = h1_q.is_write && (h1_q.address == cur.sel) && (h1_q.data == mem1_merged);
    assign hint2_ok = h2_q.is_write && (h2_q.address == cur.sel) && (h2_q.data == mem2_merged);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!kind_is_none(dest0_kind)) begin
                        state_d = WR0;
                    end else if (!kind_is_none(dest1_kind)) begin
                        state_d = WR1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WR0:     state_d = kind_is_none(d1_q.kind) ? DONE : WR1;
            WR1:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        h1_d  = h1_q;
        h2_d  = h2_q;
        r1b_d = r1b_q;
        p16_d = p16_q;
        if (accept) begin
            d0_d  = '{kind: dest0_kind, sel: dest0_sel, val: dest0_val};
            d1_d  = '{kind: dest1_kind, sel: dest1_sel, val: dest1_val};
            h1_d  = '{is_write: hint1_is_write, address: hint1_address, data: hint1_data};
            h2_d  = '{is_write: hint2_is_write, address: hint2_address, data: hint2_data};
            r1b_d = reg_1byte;
            p16_d = prefix_operand_16bit;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (idle && load_en) begin
            regs_d[REG_EAX] = load_eax;
            regs_d[REG_ECX] = load_ecx;
            regs_d[REG_EDX] = load_edx;
            regs_d[REG_EBX] = load_ebx;
            regs_d[REG_ESP] = load_esp;
            regs_d[REG_EBP] = load_ebp;
            regs_d[REG_ESI] = load_esi;
            regs_d[REG_EDI] = load_edi;
        end else if (commit_active && kind_is_reg(cur.kind)) begin
            regs_d[reg_idx] = reg_merged;
        end
    end

    assign fault_d = fault_q
                   | (commit_active && kind_is_mem(cur.kind) && !(hint1_ok || hint2_ok));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            regs_q  <= regs_d;
        end
    end

    // NOTE: holding registers are only read after an accept reloads them, so they carry no reset.
    always_ff @(posedge clk) begin
        d0_q  <= d0_d;
        d1_q  <= d1_d;
        h1_q  <= h1_d;
        h2_q  <= h2_d;
        r1b_q <= r1b_d;
        p16_q <= p16_d;
    end

    assign eax   = regs_q[REG_EAX];
    assign ecx   = regs_q[REG_ECX];
    assign edx   = regs_q[REG_EDX];
    assign ebx   = regs_q[REG_EBX];
    assign esp   = regs_q[REG_ESP];
    assign ebp   = regs_q[REG_EBP];
    assign esi   = regs_q[REG_ESI];
    assign edi   = regs_q[REG_EDI];
    assign done  = (state_q == DONE);
    assign fault = fault_q;

endmodule

// File: tb/tb_commit_dests.sv
// Self-checking bench for commit_dests: directed scenarios followed by randomized
// commits/loads checked against a register-file and fault model.
module tb_commit_dests;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  dest0_kind = '0, dest1_kind = '0;
    logic [31:0] dest0_sel = '0, dest1_sel = '0, dest0_val = '0, dest1_val = '0;
    logic        reg_1byte = 1'b0, prefix_operand_16bit = 1'b0;
    logic        hint1_is_write = 1'b0, hint2_is_write = 1'b0;
    logic [31:0] hint1_address = '0, hint1_data = '0, hint2_address = '0, hint2_data = '0;
    logic        load_en = 1'b0;
    logic [31:0] ld [8];
    logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi;
    logic        done, fault;
    logic [31:0] dut_regs [8];

    logic [31:0] m_regs [8];
    logic        m_fault;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    commit_dests dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dest0_kind(dest0_kind), .dest0_sel(dest0_sel), .dest0_val(dest0_val),
        .dest1_kind(dest1_kind), .dest1_sel(dest1_sel), .dest1_val(dest1_val),
        .reg_1byte(reg_1byte), .prefix_operand_16bit(prefix_operand_16bit),
        .hint1_is_write(hint1_is_write), .hint1_address(hint1_address), .hint1_data(hint1_data),
        .hint2_is_write(hint2_is_write), .hint2_address(hint2_address), .hint2_data(hint2_data),
        .load_en(load_en),
        .load_eax(ld[0]), .load_ecx(ld[1]), .load_edx(ld[2]), .load_ebx(ld[3]),
        .load_esp(ld[4]), .load_ebp(ld[5]), .load_esi(ld[6]), .load_edi(ld[7]),
        .eax(eax), .ecx(ecx), .edx(edx), .ebx(ebx), .esp(esp), .ebp(ebp), .esi(esi), .edi(edi),
        .done(done), .fault(fault)
    );

    always_comb begin
        dut_regs[0] = eax; dut_regs[1] = ecx; dut_regs[2] = edx; dut_regs[3] = ebx;
        dut_regs[4] = esp; dut_regs[5] = ebp; dut_regs[6] = esi; dut_regs[7] = edi;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s.reg%0d", tag, i), dut_regs[i], m_regs[i]);
        end
        check({tag, ".fault"}, 32'(fault), 32'(m_fault));
    endtask

    // Bits of the destination touched by a write of the given width.
    function automatic logic [31:0] width_mask(input logic r1b, input logic p16);
        if (r1b) return 32'h0000_00FF;
        if (p16) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_dest(input logic [1:0] kind, input logic [31:0] sel, input logic [31:0] val);
        logic [31:0] mask;
        int          idx;
        int          shift;
        bit          ok1, ok2;
        mask = width_mask(reg_1byte, prefix_operand_16bit);
        if (kind == 2'b01) begin
            idx   = int'(sel % 8);
            shift = 0;
`ifdef COMMIT_BYTE_REGS_EN
            if (reg_1byte && idx >= 4) begin
                idx   = idx - 4;
                shift = 8;
            end
`endif
            mask = mask << shift;
            m_regs[idx] = (m_regs[idx] & ~mask) | ((val << shift) & mask);
        end else if (kind >= 2'b10) begin
            ok1 = hint1_is_write && hint1_address == sel && (hint1_data & mask) == (val & mask);
            ok2 = hint2_is_write && hint2_address == sel && (hint2_data & mask) == (val & mask);
            if (!(ok1 || ok2)) m_fault = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_fault = 1'b0;
        @(negedge clk);
        check_model("reset");
        check("reset.done", 32'(done), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
    endtask

    // Load the seed from ld[]; with_valid also raises in_valid, which must not be accepted.
    task automatic do_load(input bit with_valid);
        @(posedge clk); #1;
        load_en  = 1'b1;
        in_valid = with_valid;
        @(negedge clk);
        check("load.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        load_en  = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = ld[i];
        @(negedge clk);
        check_model("load");
        check("load.no_accept", 32'(in_ready), 32'd1);
        check("load.no_done", 32'(done), 32'd0);
    endtask

    task automatic do_commit(input string tag);
        int n_dest;
        int lat;
        n_dest = int'(dest0_kind != 2'b00) + int'(dest1_kind != 2'b00);
        @(posedge clk); #1 in_valid = 1'b1;
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        check({tag, ".latency"}, 32'(lat), 32'(1 + n_dest));
        model_dest(dest0_kind, dest0_sel, dest0_val);
        model_dest(dest1_kind, dest1_sel, dest1_val);
        check_model(tag);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".back_idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic clear_req();
        dest0_kind = '0; dest1_kind = '0;
        dest0_sel = '0; dest1_sel = '0; dest0_val = '0; dest1_val = '0;
        reg_1byte = 1'b0; prefix_operand_16bit = 1'b0;
        hint1_is_write = 1'b0; hint2_is_write = 1'b0;
        hint1_address = '0; hint1_data = '0; hint2_address = '0; hint2_data = '0;
    endtask

    initial begin
        logic [31:0] mask;
        for (int i = 0; i < 8; i++) ld[i] = '0;
        do_reset();

        // 8-bit merge into eax, single destination.
        ld[0] = 32'h1122_3344;
        do_load(1'b0);
        clear_req();
        dest0_kind = 2'b01; dest0_sel = 32'd0; dest0_val = 32'hAABB_CCDD; reg_1byte = 1'b1;
        do_commit("byte_eax");
        check("byte_eax.value", eax, 32'h1122_33DD);

        // Two writes to ebx: dest1 wins.
        clear_req();
        dest0_kind = 2'b01; dest0_sel = 32'd3; dest0_val = 32'd5;
        dest1_kind = 2'b01; dest1_sel = 32'd3; dest1_val = 32'd7;
        do_commit("ebx_order");
        check("ebx_order.value", ebx, 32'd7);

        // Memory commit matched by the second memory hint, then a mismatch, then fault stays sticky.
        clear_req();
        dest0_kind = 2'b10; dest0_sel = 32'h1000; dest0_val = 32'h42;
        hint2_is_write = 1'b1; hint2_address = 32'h1000; hint2_data = 32'h42;
        do_commit("mem_ok");
        check("mem_ok.fault", 32'(fault), 32'd0);
        hint2_data = 32'h43;
        do_commit("mem_bad");
        check("mem_bad.fault", 32'(fault), 32'd1);
        hint2_data = 32'h42;
        do_commit("mem_sticky");
        check("mem_sticky.fault", 32'(fault), 32'd1);

        // No destinations: done right after accept.
        clear_req();
        do_commit("none");

        // Load with a simultaneous request.
        for (int i = 0; i < 8; i++) ld[i] = $urandom;
        do_load(1'b1);

        // Reset while the second write of a two-REG commit is in flight.
        clear_req();
        dest0_kind = 2'b01; dest0_sel = 32'd1; dest0_val = 32'hDEAD_BEEF;
        dest1_kind = 2'b01; dest1_sel = 32'd2; dest1_val = 32'hCAFE_F00D;
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort.in_wr1", 32'(done), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_fault = 1'b0;
        @(negedge clk);
        check_model("abort");
        check("abort.idle", 32'(in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("abort.no_done%0d", c), 32'(done), 32'd0);
        end

        // 8-bit write with sel 4: AH when the byte-register option is built, else low byte of esp.
        do_reset();
        for (int i = 0; i < 8; i++) ld[i] = '0;
        ld[4] = 32'hFFFF_FFFF;
        do_load(1'b0);
        clear_req();
        dest0_kind = 2'b01; dest0_sel = 32'd4; dest0_val = 32'h9A; reg_1byte = 1'b1;
        do_commit("byte_sel4");
`ifdef COMMIT_BYTE_REGS_EN
        check("byte_sel4.eax", eax, 32'h0000_9A00);
        check("byte_sel4.esp", esp, 32'hFFFF_FFFF);
`else
        check("byte_sel4.esp", esp, 32'hFFFF_FF9A);
        check("byte_sel4.eax", eax, 32'h0000_0000);
`endif

        // Randomized commits and loads.
        for (int it = 0; it < 80; it++) begin
            if (it % 20 == 19) begin
                do_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 8; i++) ld[i] = $urandom;
                do_load(1'($urandom_range(0, 1)));
            end else begin
                clear_req();
                dest0_kind = 2'($urandom_range(0, 3));
                dest1_kind = 2'($urandom_range(0, 3));
                dest0_sel  = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
                dest1_sel  = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
                dest0_val  = $urandom;
                dest1_val  = $urandom;
                reg_1byte  = 1'($urandom_range(0, 1));
                prefix_operand_16bit = 1'($urandom_range(0, 1));
                mask = width_mask(reg_1byte, prefix_operand_16bit);
                hint1_is_write = ($urandom_range(0, 3) != 0);
                hint1_address  = $urandom_range(0, 3) != 0 ? dest0_sel : $urandom;
                hint1_data     = $urandom_range(0, 3) != 0 ? ((dest0_val & mask) | ($urandom & ~mask))
                                                           : $urandom;
                hint2_is_write = ($urandom_range(0, 3) != 0);
                hint2_address  = $urandom_range(0, 1) ? dest1_sel : dest0_sel;
                hint2_data     = ($urandom_range(0, 1) ? dest1_val : dest0_val) & mask
                               | ($urandom & ~mask);
                do_commit($sformatf("rnd%0d", it));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
